dcmi_ahb_slv: RTL and testbench
===============================

# dcmi_ahb_slv

AHB-Lite slave front end for the DCMI peripheral. It converts AHB-Lite address/data-phase transfers into the single-cycle internal register bus (ahb_bus_sel/wr/rd/addr/bsel/wdata/rdata) that drives the DCMI register file directly downstream. It also generates byte-lane selects, read wait states and two-cycle ERROR responses.

## Interface
Parameters:
- REG_NUM, 8: number of implemented 32-bit words; word index >= REG_NUM is an error.
- HADDR_W, 12: width of haddr (byte address within the DCMI window).

Ports (reset rstn, asynchronous, active-low; clock hclk):
- hclk  input  1  system/AHB clock
- rstn  input  1  asynchronous active-low reset
- hsel  input  1  slave select
- htrans  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hwrite  input  1  1 = write
- hsize  input  3  transfer size
- haddr  input  HADDR_W  byte address
- hwdata  input  32  write data (data phase)
- hready_in  input  1  bus-level HREADY
- hreadyout  output  1  slave ready
- hresp  output  1  0 OKAY, 1 ERROR
- hrdata  output  32  read data
- ahb_bus_sel  output  1  internal access strobe
- ahb_bus_wr  output  1  internal write
- ahb_bus_rd  output  1  internal read
- ahb_bus_addr  output  4  word index = haddr[5:2]
- ahb_bus_bsel  output  4  byte lane enables
- ahb_bus_wdata  output  32  = hwdata (combinational pass-through)
- ahb_bus_rdata  input  32  register file read data, valid in the cycle ahb_bus_rd is high

## Operation
- Address phase accepted when hsel & htrans[1] & hready_in. BUSY, IDLE and unselected cycles give OKAY with zero wait states and no internal access.
- Error check at accept. A transfer is an error if any of the following holds:
  - hsize > 2
  - hsize==1 & haddr[0]
  - hsize==2 & haddr[1:0]!=0
  - haddr[HADDR_W-1:2] >= REG_NUM
- Byte lanes are registered at accept:
  - hsize 0: bsel = 4'b0001 << haddr[1:0]
  - hsize 1: bsel = haddr[1] ? 4'b1100 : 4'b0011
  - hsize 2: bsel = 4'b1111
- Internal outputs ahb_bus_addr/bsel/wr/rd/sel are registered from the address phase. They are valid only in the cycles listed below and are 0 otherwise.
- FSM states:
  - IDLE: hreadyout=1, hresp=0. Accept: write -> WR; read -> RD_WAIT; error -> ERR1.
  - WR: ahb_bus_sel=1, ahb_bus_wr=1, hreadyout=1. A new accept in this cycle branches as from IDLE; otherwise -> IDLE.
  - RD_WAIT: ahb_bus_sel=1, ahb_bus_rd=1, hreadyout=0. hrdata <= ahb_bus_rdata at the clock edge. -> RD_DONE.
  - RD_DONE: hreadyout=1, hrdata stable. A new accept branches as from IDLE; otherwise -> IDLE.
  - ERR1: hresp=1, hreadyout=0. -> ERR2.
  - ERR2: hresp=1, hreadyout=1. A new accept branches as from IDLE; otherwise -> IDLE.
- Errored transfers never assert ahb_bus_sel.
- hrdata holds its last read value outside RD_DONE.
- Reset values: state IDLE, hreadyout=1, hresp=0, hrdata=0, all ahb_bus_* registered outputs 0.
- Reset mid-transfer aborts it. No internal access is issued after rstn deasserts until a new accept.

## Timing
- Write: address phase cycle N; ahb_bus_wr in cycle N+1 with hwdata. The register is updated at the end of N+1. Zero wait states.
- Read: address phase N; ahb_bus_rd in N+1 with hreadyout=0; hrdata valid and hreadyout=1 in N+2. One wait state.
- Back-to-back write then read at the same address: the read returns the newly written value, because the write lands at the N+1 edge and the read samples at N+2.
- Error: hresp=1 in N+1 and N+2, with hreadyout=0 then 1.
- No address is accepted while hreadyout=0, because hready_in is low in those cycles.

## Test plan
- Word write 0x12345678 to haddr 0x004, then read 0x004: the bench sees ahb_bus_wr with addr=1, bsel=1111 one cycle after the address phase; the read returns 0x12345678 with exactly one hreadyout-low cycle.
- Byte writes to haddr 0x001 and halfword writes to haddr 0x002 -> bsel=0010 and bsel=1100 respectively, with ahb_bus_addr=0.
- Error cases -> each gives a two-cycle ERROR response (hresp=1, hreadyout 0 then 1) and no ahb_bus_sel pulse:
  - misaligned word at haddr 0x006
  - hsize=3 at haddr 0x000
  - address 0x020 with REG_NUM=8
- Pipelined burst: NONSEQ write 0x0, SEQ write 0x4, then SEQ read 0x0 -> consecutive ahb_bus_wr cycles with no bubble; the read stalls one cycle and returns the first written data.
- IDLE/BUSY transfers and hsel=0 with htrans=NONSEQ -> hreadyout stays 1, hresp=0, no ahb_bus_* activity.
- Assert rstn during RD_WAIT -> outputs return to reset values immediately. After release, an IDLE bus yields no ahb_bus_rd pulse and hrdata=0.

Source files
------------

// File: rtl/dcmi_ahb_slv.sv
`default_nettype none
// ============================================================================
// Module   : dcmi_ahb_slv
// Purpose  : AHB-Lite slave front end for the DCMI peripheral. Turns AHB-Lite
//            address/data-phase transfers into the single-cycle internal
//            register bus that drives the DCMI register file. Generates byte
//            lane selects, one read wait state and two-cycle ERROR responses.
// Ports    : hclk, rstn (async, active-low)
//            AHB-Lite : hsel, htrans, hwrite, hsize, haddr, hwdata, hready_in
//                       -> hreadyout, hresp, hrdata
//            Reg bus  : ahb_bus_sel/wr/rd/addr/bsel/wdata -> register file,
//                       ahb_bus_rdata <- register file
// Revision : 1.0 - initial release
// ============================================================================
module dcmi_ahb_slv #(
    parameter int REG_NUM = 8,
    parameter int HADDR_W = 12
) (
    input  logic               hclk,
    input  logic               rstn,
    input  logic               hsel,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [2:0]         hsize,
    input  logic [HADDR_W-1:0] haddr,
    input  logic [31:0]        hwdata,
    input  logic               hready_in,
    output logic               hreadyout,
    output logic               hresp,
    output logic [31:0]        hrdata,
    output logic               ahb_bus_sel,
    output logic               ahb_bus_wr,
    output logic               ahb_bus_rd,
    output logic [3:0]         ahb_bus_addr,
    output logic [3:0]         ahb_bus_bsel,
    output logic [31:0]        ahb_bus_wdata,
    input  logic [31:0]        ahb_bus_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_DONE = 3'd3,
        ST_ERR1    = 3'd4,
        ST_ERR2    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_accept_state;
    logic        w_open;
    logic        w_accept;
    logic        w_err;
    logic [31:0] w_word_idx;
    logic [3:0]  w_bsel;
    logic [3:0]  r_addr;
    logic [3:0]  r_bsel;
    logic [31:0] r_hrdata;
    logic        w_unused;

    // htrans[0] only distinguishes SEQ from NONSEQ, which this slave treats alike
    assign w_unused = htrans[0];

    // Slave is only able to take a new address phase in cycles where it drives
    // hreadyout high; gating here keeps a misbehaving master from disturbing
    // a pending read or error response.
    assign w_open   = (r_state != ST_RD_WAIT) && (r_state != ST_ERR1);
    assign w_accept = hsel & htrans[1] & hready_in & w_open;

    assign w_word_idx = 32'(haddr[HADDR_W-1:2]);
    assign w_err = (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
                 | (w_word_idx >= 32'(REG_NUM));

    always_comb begin
        w_bsel = 4'b0000;
        case (hsize)
            3'd0:    w_bsel = 4'b0001 << haddr[1:0];
            3'd1:    w_bsel = haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_bsel = 4'b1111;
            default: w_bsel = 4'b0000;
        endcase
    end

    always_comb begin
        w_accept_state = ST_RD_WAIT;
        if (w_err) begin
            w_accept_state = ST_ERR1;
        end else if (hwrite) begin
            w_accept_state = ST_WR;
        end
    end

    always_ff @(posedge hclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        hreadyout   = 1'b1;
        hresp       = 1'b0;
        ahb_bus_sel = 1'b0;
        ahb_bus_wr  = 1'b0;
        ahb_bus_rd  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = w_accept ? w_accept_state : ST_IDLE;
            end
            ST_WR: begin
                ahb_bus_sel = 1'b1;
                ahb_bus_wr  = 1'b1;
                w_state_nxt = w_accept ? w_accept_state : ST_IDLE;
            end
            ST_RD_WAIT: begin
                ahb_bus_sel = 1'b1;
                ahb_bus_rd  = 1'b1;
                hreadyout   = 1'b0;
                w_state_nxt = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                w_state_nxt = w_accept ? w_accept_state : ST_IDLE;
            end
            ST_ERR1: begin
                hresp       = 1'b1;
                hreadyout   = 1'b0;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                hresp       = 1'b1;
                w_state_nxt = w_accept ? w_accept_state : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word index and lanes are captured only for good transfers and cleared
    // otherwise, so they read as zero outside the access cycle.
    always_ff @(posedge hclk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= 4'd0;
            r_bsel <= 4'd0;
        end else if (w_accept && !w_err) begin
            r_addr <= haddr[5:2];
            r_bsel <= w_bsel;
        end else begin
            r_addr <= 4'd0;
            r_bsel <= 4'd0;
        end
    end

    always_ff @(posedge hclk or negedge rstn) begin
        if (!rstn) begin
            r_hrdata <= 32'd0;
        end else if (r_state == ST_RD_WAIT) begin
            r_hrdata <= ahb_bus_rdata;
        end
    end

    assign ahb_bus_addr  = r_addr;
    assign ahb_bus_bsel  = r_bsel;
    assign ahb_bus_wdata = hwdata;
    assign hrdata        = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_dcmi_ahb_slv.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcmi_ahb_slv
// Purpose  : Self-checking bench for dcmi_ahb_slv. Stimulus queues expected
//            register-bus accesses and AHB responses; monitors pop and compare
//            them when the DUT presents them. A small register file model
//            sits on the internal bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcmi_ahb_slv;

    logic        hclk;
    logic        rstn;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [11:0] haddr;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        ahb_bus_sel;
    logic        ahb_bus_wr;
    logic        ahb_bus_rd;
    logic [3:0]  ahb_bus_addr;
    logic [3:0]  ahb_bus_bsel;
    logic [31:0] ahb_bus_wdata;
    logic [31:0] ahb_bus_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [3:0]  bsel;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] rdata;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    dcmi_ahb_slv #(.REG_NUM(8), .HADDR_W(12)) u_dut (
        .hclk          (hclk),
        .rstn          (rstn),
        .hsel          (hsel),
        .htrans        (htrans),
        .hwrite        (hwrite),
        .hsize         (hsize),
        .haddr         (haddr),
        .hwdata        (hwdata),
        .hready_in     (hready_in),
        .hreadyout     (hreadyout),
        .hresp         (hresp),
        .hrdata        (hrdata),
        .ahb_bus_sel   (ahb_bus_sel),
        .ahb_bus_wr    (ahb_bus_wr),
        .ahb_bus_rd    (ahb_bus_rd),
        .ahb_bus_addr  (ahb_bus_addr),
        .ahb_bus_bsel  (ahb_bus_bsel),
        .ahb_bus_wdata (ahb_bus_wdata),
        .ahb_bus_rdata (ahb_bus_rdata)
    );

    assign hready_in = hreadyout;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Register file model downstream of the internal bus (not reset)
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    end
    assign ahb_bus_rdata = mem[ahb_bus_addr];
    always @(posedge hclk) begin
        if (ahb_bus_sel && ahb_bus_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (ahb_bus_bsel[b]) mem[ahb_bus_addr][b*8 +: 8] <= ahb_bus_wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: internal bus pulses and AHB data-phase responses
    // ------------------------------------------------------------------
    bit          pending   = 1'b0;
    bit          first_set = 1'b0;
    bit          first_rsp = 1'b0;
    bit          prev_acc  = 1'b0;
    int          waits     = 0;

    always @(negedge hclk) begin
        bus_t e;
        rsp_t r;
        logic [3:0] got_t;
        logic [3:0] exp_t;
        if (!rstn) begin
            checks++;
            if ({hreadyout, hresp, hrdata, ahb_bus_sel, ahb_bus_wr, ahb_bus_rd,
                 ahb_bus_addr, ahb_bus_bsel} != {1'b1, 1'b0, 32'd0, 11'd0}) begin
                errors++;
                $display("FAIL reset_vals: got rdy=%b resp=%b rdata=%h sel=%b wr=%b rd=%b addr=%h bsel=%b, want rdy=1 resp=0 rdata=0 bus=0",
                         hreadyout, hresp, hrdata, ahb_bus_sel, ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel);
            end
            pending  = 1'b0;
            prev_acc = 1'b0;
            rsp_q.delete();
        end else begin
            // internal register bus
            if (ahb_bus_sel) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got sel=1 wr=%b rd=%b addr=%h bsel=%b, want no access",
                             ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel);
                end else begin
                    e = bus_q.pop_front();
                    if ({prev_acc, ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel,
                         (ahb_bus_wr ? ahb_bus_wdata : 32'd0)} !=
                        {1'b1, e.wr, !e.wr, e.addr, e.bsel, (e.wr ? e.wdata : 32'd0)}) begin
                        errors++;
                        $display("FAIL bus_access: got after_acc=%b wr=%b rd=%b addr=%h bsel=%b wdata=%h, want after_acc=1 wr=%b rd=%b addr=%h bsel=%b wdata=%h",
                                 prev_acc, ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel, ahb_bus_wdata,
                                 e.wr, !e.wr, e.addr, e.bsel, e.wdata);
                    end
                end
            end else begin
                checks++;
                if ({ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel} != 10'd0) begin
                    errors++;
                    $display("FAIL bus_idle: got wr=%b rd=%b addr=%h bsel=%b, want all 0",
                             ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel);
                end
            end
            // AHB data phase
            if (pending) begin
                if (!first_set) begin
                    first_rsp = hresp;
                    first_set = 1'b1;
                end
                if (!hreadyout) begin
                    waits++;
                    if (waits > 5) begin
                        checks++;
                        errors++;
                        $display("FAIL data_phase_stuck: got %0d wait states, want at most 1", waits);
                        pending = 1'b0;
                    end
                end else begin
                    pending = 1'b0;
                    checks++;
                    if (rsp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: got a data phase, want none");
                    end else begin
                        r = rsp_q.pop_front();
                        got_t = {2'(waits), first_rsp, hresp};
                        exp_t = r.err ? 4'b0111 : (r.rd ? 4'b0100 : 4'b0000);
                        if (got_t != exp_t) begin
                            errors++;
                            $display("FAIL rsp_timing: got waits=%0d resp=%b,%b want waits=%0d resp=%b,%b",
                                     got_t[3:2], got_t[1], got_t[0], exp_t[3:2], exp_t[1], exp_t[0]);
                        end
                        if (r.rd && !r.err) begin
                            checks++;
                            if (hrdata !== r.rdata) begin
                                errors++;
                                $display("FAIL rdata: got %h want %h", hrdata, r.rdata);
                            end
                        end
                    end
                end
            end else begin
                checks++;
                if (!hreadyout || hresp) begin
                    errors++;
                    $display("FAIL idle_rsp: got rdy=%b resp=%b want rdy=1 resp=0", hreadyout, hresp);
                end
            end
            prev_acc = hsel & htrans[1] & hready_in;
            if (prev_acc) begin
                pending   = 1'b1;
                waits     = 0;
                first_set = 1'b0;
            end
        end
    end

    // Reset must take effect without waiting for a clock edge
    always @(negedge rstn) begin
        #1;
        checks++;
        if ({hreadyout, hresp, hrdata, ahb_bus_sel, ahb_bus_wr, ahb_bus_rd,
             ahb_bus_addr, ahb_bus_bsel} != {1'b1, 1'b0, 32'd0, 11'd0}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b resp=%b rdata=%h sel=%b wr=%b rd=%b addr=%h bsel=%b, want rdy=1 resp=0 rdata=0 bus=0",
                     hreadyout, hresp, hrdata, ahb_bus_sel, ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // One address phase; returns just after the edge that accepted it, having
    // put the write data on hwdata for the data phase.
    task automatic xfer(input bit s, input logic [1:0] tr, input bit wr,
                        input logic [2:0] sz, input logic [11:0] a,
                        input logic [31:0] wd, input bit exp_err,
                        input logic [3:0] exp_addr, input logic [3:0] exp_bsel,
                        input logic [31:0] exp_rdata);
        bit ok;
        int n;
        hsel   = s;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        if (s && tr[1]) begin
            rsp_q.push_back('{err: exp_err, rd: !wr, rdata: exp_rdata});
            if (!exp_err) bus_q.push_back('{wr: wr, addr: exp_addr, bsel: exp_bsel, wdata: wd});
        end
        n  = 0;
        ok = 1'b0;
        do begin
            @(negedge hclk);
            ok = hreadyout;
            @(posedge hclk);
            #1;
            n++;
        end while (!ok && n < 20);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got hreadyout=0 for %0d cycles, want 1", n);
        end
        if (wr) hwdata = wd;
    endtask

    task automatic idle(input int n);
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin
        rstn   = 1'b1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        haddr  = 12'h0;
        hwdata = 32'h0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge hclk);
        #1 rstn = 1'b1;
        idle(2);

        // word write then back-to-back read of the same word
        xfer(1, 2'b10, 1, 3'd2, 12'h004, 32'h12345678, 0, 4'd1, 4'b1111, 32'h0);
        xfer(1, 2'b10, 0, 3'd2, 12'h004, 32'h0,        0, 4'd1, 4'b1111, 32'h12345678);
        idle(2);

        // byte lanes
        xfer(1, 2'b10, 1, 3'd0, 12'h001, 32'h0000AB00, 0, 4'd0, 4'b0010, 32'h0);
        xfer(1, 2'b10, 1, 3'd1, 12'h002, 32'hCDEF0000, 0, 4'd0, 4'b1100, 32'h0);
        xfer(1, 2'b10, 1, 3'd0, 12'h01F, 32'h5A000000, 0, 4'd7, 4'b1000, 32'h0);
        xfer(1, 2'b10, 0, 3'd2, 12'h000, 32'h0,        0, 4'd0, 4'b1111, 32'hCDEFAB00);
        idle(2);

        // error responses
        xfer(1, 2'b10, 1, 3'd2, 12'h006, 32'hDEADBEEF, 1, 4'd0, 4'b0000, 32'h0);
        xfer(1, 2'b10, 0, 3'd3, 12'h000, 32'h0,        1, 4'd0, 4'b0000, 32'h0);
        xfer(1, 2'b10, 1, 3'd2, 12'h020, 32'hDEADBEEF, 1, 4'd0, 4'b0000, 32'h0);
        xfer(1, 2'b10, 0, 3'd1, 12'h003, 32'h0,        1, 4'd0, 4'b0000, 32'h0);
        idle(2);

        // transfers that must be ignored
        xfer(1, 2'b00, 1, 3'd2, 12'h004, 32'hFFFFFFFF, 0, 4'd0, 4'b0000, 32'h0);
        xfer(1, 2'b01, 1, 3'd2, 12'h004, 32'hFFFFFFFF, 0, 4'd0, 4'b0000, 32'h0);
        xfer(0, 2'b10, 1, 3'd2, 12'h004, 32'hFFFFFFFF, 0, 4'd0, 4'b0000, 32'h0);
        idle(2);

        // pipelined burst
        xfer(1, 2'b10, 1, 3'd2, 12'h000, 32'h11111111, 0, 4'd0, 4'b1111, 32'h0);
        xfer(1, 2'b11, 1, 3'd2, 12'h004, 32'h22222222, 0, 4'd1, 4'b1111, 32'h0);
        xfer(1, 2'b11, 0, 3'd2, 12'h000, 32'h0,        0, 4'd0, 4'b1111, 32'h11111111);
        idle(2);

        // reset in the read wait state
        xfer(1, 2'b10, 0, 3'd2, 12'h004, 32'h0, 0, 4'd1, 4'b1111, 32'h22222222);
        hsel   = 1'b0;
        htrans = 2'b00;
        @(negedge hclk);
        #1 rstn = 1'b0;
        repeat (2) @(posedge hclk);
        #1 rstn = 1'b1;
        idle(3);

        // normal operation after reset
        xfer(1, 2'b10, 0, 3'd2, 12'h01C, 32'h0, 0, 4'd7, 4'b1111, 32'h5A000000);
        idle(3);

        checks++;
        if (bus_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got bus=%0d rsp=%0d left, want 0 0", bus_q.size(), rsp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
